mfsc_feature_sender: RTL and testbench

MFSC_FEATURE_SENDER -- requirements
Module: mfsc_feature_sender

---
 rtl/mfsc_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/mfsc_feature_sender.sv | 97 +++++++++
 tb/tb_mfsc_feature_sender.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfsc_pkg.sv
// Shared defaults, state encoding and counter sizing for the MFSC sender.
package mfsc_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int N_SAMPLES_DEF  = 1280;
  localparam int FIFO_DEPTH_DEF = 16;

  // Sample counters must be able to hold N_SAMPLES itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_w(N_SAMPLES_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head is shown combinationally, zero when empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Extra pointer bit tells full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mfsc_feature_sender.sv
// Streams one MFSC feature map to the ShuffleNet memory controller.
// Define MFSC_SEND_CLAMP_EN to write negative samples as zero.
module mfsc_feature_sender
  import mfsc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int N_SAMPLES  = N_SAMPLES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              log10_result_Rready,
  output logic [DATA_W-1:0] log10_result,
  input  logic              log10_result_Wready,
  input  logic              shuffleNet_Result_Ready,
  output logic              map_done,
  output logic              busy
);

  localparam int CNT_W = cnt_w(N_SAMPLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  sent_cnt;
  logic              full;
  logic              empty;
  logic              wr_en;
  logic              rd_en;
  logic              last_xfer;
  logic              hold_exit;
  logic [DATA_W-1:0] wr_data;

`ifdef MFSC_SEND_CLAMP_EN
  assign wr_data = in_data[DATA_W-1] ? '0 : in_data;
`else
  assign wr_data = in_data;
`endif

  // Stop accepting once a whole map is in, until HOLD is released.
  assign in_ready = !full && (state != HOLD) && (acc_cnt < LAST);
  assign wr_en    = in_valid && in_ready;

  assign log10_result_Rready = (state == STREAM) && !empty;
  assign rd_en     = log10_result_Rready && log10_result_Wready;
  assign last_xfer = rd_en && (sent_cnt == LAST - 1'b1);
  assign hold_exit = (state == HOLD) && shuffleNet_Result_Ready;
  assign busy      = (state != IDLE);

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (log10_result),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = STREAM;
      STREAM:  if (last_xfer) state_nxt = HOLD;
      HOLD:    if (shuffleNet_Result_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc_cnt  <= '0;
      sent_cnt <= '0;
      map_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      map_done <= last_xfer;
      if (hold_exit) begin
        acc_cnt  <= '0;
        sent_cnt <= '0;
      end else begin
        if (wr_en) acc_cnt  <= acc_cnt + 1'b1;
        if (rd_en) sent_cnt <= sent_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mfsc_feature_sender.sv
// Self-checking bench for mfsc_feature_sender against a queue model.
// Works with and without MFSC_SEND_CLAMP_EN defined.
module tb_mfsc_feature_sender;
  import mfsc_pkg::*;

  localparam int N = N_SAMPLES_DEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        log10_result_Rready;
  logic [15:0] log10_result;
  logic        log10_result_Wready;
  logic        shuffleNet_Result_Ready;
  logic        map_done;
  logic        busy;

  mfsc_feature_sender dut (
    .clk                     (clk),
    .reset                   (reset),
    .in_valid                (in_valid),
    .in_data                 (in_data),
    .in_ready                (in_ready),
    .log10_result_Rready     (log10_result_Rready),
    .log10_result            (log10_result),
    .log10_result_Wready     (log10_result_Wready),
    .shuffleNet_Result_Ready (shuffleNet_Result_Ready),
    .map_done                (map_done),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: samples in flight in arrival order, plus per-map tallies.
  logic [15:0] exp_q[$];
  int n_up;
  int n_dn;
  int n_done;

  function automatic logic [15:0] ref_clamp(input logic [15:0] d);
`ifdef MFSC_SEND_CLAMP_EN
    return ($signed(d) < 0) ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  task automatic step(output bit dn,
                      output logic [15:0] got,
                      output logic [15:0] want);
    bit up;
    up   = in_valid && in_ready;
    dn   = log10_result_Rready && log10_result_Wready;
    got  = log10_result;
    want = 'x;
    if (dn) begin
      if (exp_q.size() > 0) want = exp_q.pop_front();
      n_dn++;
    end
    if (up) begin
      exp_q.push_back(ref_clamp(in_data));
      n_up++;
    end
    @(posedge clk);
    #1;
    if (map_done) n_done++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    log10_result_Wready = 1'b0;
    shuffleNet_Result_Ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    n_up = 0;
    n_dn = 0;
    n_done = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready: got %b, expected 1", in_ready);
    end
    checks++;
    if (log10_result_Rready !== 1'b0) begin
      errors++;
      $display("FAIL rst_rready: got %b, expected 0", log10_result_Rready);
    end
    checks++;
    if (log10_result !== 16'h0000) begin
      errors++;
      $display("FAIL rst_result: got %h, expected 0000", log10_result);
    end
    checks++;
    if (map_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_map_done: got %b, expected 0", map_done);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b, expected 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    bit dn;
    logic [15:0] got, want;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'($urandom);
      step(dn, got, want);
    end
    in_valid = 1'b0;
    checks++;
    if (log10_result_Rready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: rready %b busy %b, expected 1 1",
               log10_result_Rready, busy);
    end
    do_reset();
    checks++;
    if (log10_result_Rready !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_post: rready %b in_ready %b busy %b, expected 0 1 0",
               log10_result_Rready, in_ready, busy);
    end
    in_valid = 1'b1;
    in_data = 16'h0011;
    step(dn, got, want);
    in_valid = 1'b0;
    log10_result_Wready = 1'b1;
    checks++;
    if (log10_result_Rready !== 1'b1 || log10_result !== 16'h0011) begin
      errors++;
      $display("FAIL midrst_first: rready %b data %h, expected 1 0011",
               log10_result_Rready, log10_result);
    end
    step(dn, got, want);
    checks++;
    if (dn !== 1'b1 || got !== 16'h0011) begin
      errors++;
      $display("FAIL midrst_xfer: dn %b data %h, expected 1 0011", dn, got);
    end
    checks++;
    if (log10_result_Rready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_leftover: rready %b, expected 0",
               log10_result_Rready);
    end
  endtask

  task automatic test_clamp();
    bit dn;
    logic [15:0] got, want, exp_c;
`ifdef MFSC_SEND_CLAMP_EN
    exp_c = 16'h0000;
`else
    exp_c = 16'hFF80;
`endif
    do_reset();
    in_valid = 1'b1;
    in_data = 16'hFF80;
    step(dn, got, want);
    in_valid = 1'b0;
    checks++;
    if (log10_result_Rready !== 1'b1 || log10_result !== exp_c) begin
      errors++;
      $display("FAIL clamp: rready %b data %h, expected 1 %h",
               log10_result_Rready, log10_result, exp_c);
    end
    log10_result_Wready = 1'b1;
    step(dn, got, want);
  endtask

  task automatic test_backpressure();
    bit dn;
    logic [15:0] got, want;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      in_valid = (n_up < 20);
      in_data = 16'(n_up);
      if (n_up >= 1) begin
        checks++;
        if (log10_result_Rready !== 1'b1 || log10_result !== 16'h0000) begin
          errors++;
          $display("FAIL bp_hold c%0d: rready %b data %h, expected 1 0000",
                   c, log10_result_Rready, log10_result);
        end
      end
      step(dn, got, want);
    end
    checks++;
    if (n_up !== 16 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full: accepted %0d in_ready %b, expected 16 0",
               n_up, in_ready);
    end
    log10_result_Wready = 1'b1;
    for (int c = 0; c < 200 && n_dn < 20; c++) begin
      in_valid = (n_up < 20);
      in_data = 16'(n_up);
      step(dn, got, want);
      if (dn) begin
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL bp_data #%0d: got %h, expected %h", n_dn - 1, got, want);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_dn !== 20 || n_up !== 20) begin
      errors++;
      $display("FAIL bp_drain: sent %0d accepted %0d, expected 20 20",
               n_dn, n_up);
    end
  endtask

  task automatic test_back_to_back();
    bit dn;
    logic [15:0] got, want;
    do_reset();
    in_valid = 1'b1;
    log10_result_Wready = 1'b1;
    for (int c = 0; c < 3 * N && n_dn < N; c++) begin
      in_data = 16'(n_up);
      step(dn, got, want);
      if (dn) begin
        checks++;
        if (got !== want || got !== 16'(n_dn - 1)) begin
          errors++;
          $display("FAIL b2b_data #%0d: got %h, expected %h", n_dn - 1, got, want);
        end
      end
    end
    checks++;
    if (n_dn !== N || map_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: sent %0d map_done %b, expected %0d 1",
               n_dn, map_done, N);
    end
    step(dn, got, want);
    checks++;
    if (map_done !== 1'b0 || n_done !== 1) begin
      errors++;
      $display("FAIL b2b_pulse: map_done %b pulses %0d, expected 0 1",
               map_done, n_done);
    end
    checks++;
    if (n_up !== N || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: accepted %0d in_ready %b, expected %0d 0",
               n_up, in_ready, N);
    end
  endtask

  task automatic test_hold();
    bit dn;
    logic [15:0] got, want;
    in_valid = 1'b1;
    shuffleNet_Result_Ready = 1'b0;
    for (int c = 0; c < 50; c++) begin
      in_data = 16'($urandom);
      checks++;
      if (in_ready !== 1'b0 || log10_result_Rready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold c%0d: in_ready %b rready %b busy %b, expected 0 0 1",
                 c, in_ready, log10_result_Rready, busy);
      end
      step(dn, got, want);
    end
    shuffleNet_Result_Ready = 1'b1;
    step(dn, got, want);
    shuffleNet_Result_Ready = 1'b0;
    n_up = 0;
    n_dn = 0;
    n_done = 0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_exit: busy %b in_ready %b, expected 0 1",
               busy, in_ready);
    end
    in_data = 16'($urandom);
    log10_result_Wready = 1'b0;
    step(dn, got, want);
    checks++;
    if (log10_result_Rready !== 1'b1 || log10_result !== exp_q[0]) begin
      errors++;
      $display("FAIL hold_next: rready %b data %h, expected 1 %h",
               log10_result_Rready, log10_result, exp_q[0]);
    end
  endtask

  // Second map under random traffic; also proves the counters restarted.
  task automatic test_random_map();
    bit dn;
    logic [15:0] got, want;
    for (int c = 0; c < 10 * N && n_dn < N; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = 16'($urandom);
      log10_result_Wready = ($urandom_range(0, 2) != 0);
      step(dn, got, want);
      if (dn) begin
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL rnd_data #%0d: got %h, expected %h", n_dn - 1, got, want);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_dn !== N || n_up !== N || map_done !== 1'b1 || n_done !== 1) begin
      errors++;
      $display("FAIL rnd_done: sent %0d acc %0d map_done %b pulses %0d, expected %0d %0d 1 1",
               n_dn, n_up, map_done, n_done, N, N);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mid_reset();
    test_clamp();
    test_backpressure();
    test_back_to_back();
    test_hold();
    test_random_map();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
